ep_bin_sequencer: RTL and testbench

EP_BIN_SEQUENCER -- requirements
Module: ep_bin_sequencer

---
 rtl/ep_bin_sequencer.sv | 119 +++++++++++
 tb/tb_ep_bin_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ep_bin_sequencer.sv
// Binary-arithmetic bin burst sequencer.
// Decodes up to MAX_BINS bins per burst and fetches bitstream bytes on demand.
module ep_bin_sequencer #(
  parameter int MAX_BINS = 16,
  parameter int VALUE_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [8:0]          range_in,
  input  logic [VALUE_W-1:0]  value_in,
  input  logic [3:0]          bits_needed_in,
  input  logic                start,
  input  logic [4:0]          num_bins,
  output logic                byte_req,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                busy,
  output logic                done,
  output logic [MAX_BINS-1:0] bins_out,
  output logic [VALUE_W-1:0]  value_out,
  output logic [3:0]          bits_needed_out
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DECODE    = 2'd1;
  localparam logic [1:0] WAIT_BYTE = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [4:0] MAX_N  = 5'(MAX_BINS);
  localparam logic [3:0] BN_MIN = 4'b1000;

  logic [1:0]          state;
  logic [8:0]          range_q;
  logic [VALUE_W-1:0]  value_q;
  logic [3:0]          bits_q;
  logic [MAX_BINS-1:0] bins_q;
  logic [4:0]          cnt_q;
  logic [4:0]          nb_q;

  logic [VALUE_W-1:0]  v2;
  logic [VALUE_W-1:0]  vx;
  logic [VALUE_W-1:0]  s;
  logic [VALUE_W-1:0]  vnext;
  logic [3:0]          bn;
  logic                bin;
  logic                last;
  logic                fin;
  logic [4:0]          nb_clamp;

  always_comb begin
    v2 = value_q << 1;
    vx = v2;
    if (state == WAIT_BYTE)
      vx = v2 + VALUE_W'(byte_data);
    s = VALUE_W'(range_q) << 7;
    bin = (vx >= s);
    vnext = bin ? (vx - s) : vx;
    bn = bits_q + 4'd1;
    last = ((cnt_q + 5'd1) == nb_q);
    nb_clamp = (num_bins > MAX_N) ? MAX_N : num_bins;
    // a bin finishes either locally (bn<0) or when the byte arrives
    fin = ((state == DECODE) && bn[3])
       || ((state == WAIT_BYTE) && byte_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      range_q <= 9'd256;
      value_q <= '0;
      bits_q  <= BN_MIN;
      bins_q  <= '0;
      cnt_q   <= '0;
      nb_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            range_q <= range_in;
            value_q <= value_in;
            bits_q  <= bits_needed_in;
          end
          if (start) begin
            nb_q   <= nb_clamp;
            bins_q <= '0;
            cnt_q  <= '0;
            state  <= (nb_clamp == 5'd0) ? DONE : DECODE;
          end
        end
        DECODE: begin
          if (bn[3])
            bits_q <= bn;
          else
            state <= WAIT_BYTE;
        end
        WAIT_BYTE: begin
          if (byte_valid)
            bits_q <= BN_MIN;
        end
        default: state <= IDLE;
      endcase
      if (fin) begin
        value_q <= vnext;
        bins_q  <= {bins_q[MAX_BINS-2:0], bin};
        cnt_q   <= cnt_q + 5'd1;
        state   <= last ? DONE : DECODE;
      end
    end
  end

  assign busy            = (state == DECODE) || (state == WAIT_BYTE);
  assign byte_req        = (state == WAIT_BYTE);
  assign done            = (state == DONE);
  assign bins_out        = bins_q;
  assign value_out       = value_q;
  assign bits_needed_out = bits_q;

endmodule

// File: tb/tb_ep_bin_sequencer.sv
// Directed bench for ep_bin_sequencer.
// Table of bursts plus reset and disturbance sequences.
module tb_ep_bin_sequencer;

  logic        clk = 1'b0;
  logic        reset, load, start, byte_valid;
  logic [8:0]  range_in;
  logic [31:0] value_in;
  logic [3:0]  bits_needed_in;
  logic [4:0]  num_bins;
  logic [7:0]  byte_data;
  logic        byte_req, busy, done;
  logic [15:0] bins_out;
  logic [31:0] value_out;
  logic [3:0]  bits_needed_out;

  int total = 0;
  int bad   = 0;

  ep_bin_sequencer dut (
    .clk(clk), .reset(reset), .load(load), .range_in(range_in),
    .value_in(value_in), .bits_needed_in(bits_needed_in),
    .start(start), .num_bins(num_bins), .byte_req(byte_req),
    .byte_valid(byte_valid), .byte_data(byte_data), .busy(busy),
    .done(done), .bins_out(bins_out), .value_out(value_out),
    .bits_needed_out(bits_needed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  rng;
    logic [31:0] val;
    logic [3:0]  bits;
    logic [4:0]  nb;
    int          dly;
    logic [7:0]  bd;
    bit          disturb;
    logic [15:0] e_bins;
    logic [31:0] e_val;
    logic [3:0]  e_bits;
    int          e_busy;
    int          e_req;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int idx, input vec_t v);
    int nbusy = 0;
    int nreq  = 0;
    int ndone = 0;
    int waited = 0;
    bit seen = 0;
    string t;
    t = $sformatf("v%0d", idx);
    if (v.disturb) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    load = 1'b1; start = 1'b1;
    range_in = v.rng; value_in = v.val;
    bits_needed_in = v.bits; num_bins = v.nb;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (v.disturb && c == 0) begin
        load = 1'b1; start = 1'b1;
        range_in = 9'd300; value_in = 32'hFFFF;
        bits_needed_in = 4'hF; num_bins = 5'd1;
      end else begin
        load = 1'b0; start = 1'b0;
      end
      if (busy) nbusy++;
      if (byte_req) nreq++;
      if (done) begin ndone++; seen = 1; end
      byte_valid = 1'b0;
      if (byte_req) begin
        if (waited >= v.dly) begin
          byte_valid = 1'b1;
          byte_data  = v.bd;
          waited = 0;
        end else waited++;
      end
      if (!seen) @(negedge clk);
    end
    load = 1'b0; start = 1'b0; byte_valid = 1'b0;
    chk({t, "_done_seen"}, 32'(ndone), 32'd1);
    chk({t, "_busy_cycles"}, 32'(nbusy), 32'(v.e_busy));
    chk({t, "_req_cycles"}, 32'(nreq), 32'(v.e_req));
    chk({t, "_bins"}, 32'(bins_out), 32'(v.e_bins));
    chk({t, "_value"}, value_out, v.e_val);
    chk({t, "_bits"}, 32'(bits_needed_out), 32'(v.e_bits));
    @(negedge clk);
    chk({t, "_done_fall"}, 32'(done), 32'd0);
    chk({t, "_idle_busy"}, 32'(busy), 32'd0);
    chk({t, "_hold_value"}, value_out, v.e_val);
    chk({t, "_hold_bins"}, 32'(bins_out), 32'(v.e_bins));
  endtask

  initial begin
    bit got_req;
    int nd;
    int nb;
    tbl[0] = '{9'd289, 32'd36049, 4'h8, 5'd4, 0, 8'h00, 1'b0,
               16'h000F, 32'd21904, 4'hC, 4, 0};
    tbl[1] = '{9'd256, 32'd20000, 4'hF, 5'd1, 3, 8'h80, 1'b0,
               16'h0001, 32'd7360, 4'h8, 5, 4};
    tbl[2] = '{9'd300, 32'd1234, 4'hD, 5'd0, 0, 8'h00, 1'b0,
               16'h0000, 32'd1234, 4'hD, 0, 0};
    tbl[3] = '{9'd510, 32'd100, 4'h8, 5'd2, 0, 8'h00, 1'b0,
               16'h0000, 32'd400, 4'hA, 2, 0};
    tbl[4] = '{9'd256, 32'd16000, 4'hE, 5'd3, 0, 8'hFF, 1'b0,
               16'h0003, 32'd30206, 4'h9, 4, 1};
    tbl[5] = '{9'd256, 32'd0, 4'h8, 5'd20, 0, 8'h00, 1'b0,
               16'h0000, 32'd0, 4'h8, 18, 2};
    tbl[6] = '{9'd256, 32'd16000, 4'hE, 5'd3, 1, 8'hFF, 1'b1,
               16'h0003, 32'd30206, 4'h9, 5, 2};

    reset = 1'b1; load = 1'b0; start = 1'b0; byte_valid = 1'b0;
    range_in = '0; value_in = '0; bits_needed_in = '0;
    num_bins = '0; byte_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(byte_req), 32'd0);
    chk("rst_value", value_out, 32'd0);
    chk("rst_bits", 32'(bits_needed_out), 32'h8);
    chk("rst_bins", 32'(bins_out), 32'd0);

    // reset wins over load and start in the same cycle
    load = 1'b1; start = 1'b1; value_in = 32'd555;
    bits_needed_in = 4'hF; num_bins = 5'd3;
    @(negedge clk);
    reset = 1'b0; load = 1'b0; start = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_value", value_out, 32'd0);
    chk("prio_bits", 32'(bits_needed_out), 32'h8);
    @(negedge clk);
    chk("prio_idle", 32'(busy | done), 32'd0);

    for (int i = 0; i < 7; i++) run(i, tbl[i]);

    // reset while waiting for a byte
    @(negedge clk);
    load = 1'b1; start = 1'b1; range_in = 9'd256;
    value_in = 32'd20000; bits_needed_in = 4'hF; num_bins = 5'd1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    got_req = 0;
    for (int c = 0; c < 10 && !got_req; c++) begin
      if (byte_req) got_req = 1;
      else @(negedge clk);
    end
    chk("wrst_req_seen", 32'(got_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("wrst_req", 32'(byte_req), 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_done", 32'(done), 32'd0);
    chk("wrst_value", value_out, 32'd0);
    chk("wrst_bits", 32'(bits_needed_out), 32'h8);
    chk("wrst_bins", 32'(bins_out), 32'd0);
    byte_valid = 1'b1; byte_data = 8'h80;
    nd = 0; nb = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    byte_valid = 1'b0;
    chk("stray_done", 32'(nd), 32'd0);
    chk("stray_busy", 32'(nb), 32'd0);
    chk("stray_value", value_out, 32'd0);
    chk("stray_bits", 32'(bits_needed_out), 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
